// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side and core-side signals of the UART transmit FIFO
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic [7:0]       wrData;
    logic             wrEn;
    logic             flush;
    logic             ovfClear;
    logic [CNT_W-1:0] lowWater;
    logic             irqEn;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] level;
    logic             overflow;
    logic             lowWaterIrq;
    logic [7:0]       txDataOut;
    logic             txDataLoadEn;
    logic             txReady;
    modport master (
        output wrData, wrEn, flush, ovfClear, lowWater, irqEn, txReady,
        input  full, empty, level, overflow, lowWaterIrq, txDataOut, txDataLoadEn
    );
    modport slave (
        input  wrData, wrEn, flush, ovfClear, lowWater, irqEn, txReady,
        output full, empty, level, overflow, lowWaterIrq, txDataOut, txDataLoadEn
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining into the UART core holding register, paced by txReady
module uart_tx_fifo #(parameter int DEPTH = 16) (
    input logic           clk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = CNT_W - 1;
    typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_t;
    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] level, levelNext;
    logic             push, pop, drop;
    assign bus.full  = level == CNT_W'(DEPTH);
    assign bus.empty = level == '0;
    assign bus.level = level;
    // flush wins over both ends: a same-cycle push is discarded silently and no pop starts
    assign push      = bus.wrEn && !bus.full && !bus.flush;
    assign drop      = bus.wrEn && bus.full && !bus.flush;
    assign pop       = state == IDLE && bus.txReady && !bus.empty && !bus.flush;
    assign levelNext = bus.flush ? '0 : level + CNT_W'(push) - CNT_W'(pop);
    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= bus.wrData;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state            <= IDLE;
            wrPtr            <= '0;
            rdPtr            <= '0;
            level            <= '0;
            bus.overflow     <= 1'b0;
            bus.lowWaterIrq  <= 1'b0;
            bus.txDataOut    <= 8'h00;
            bus.txDataLoadEn <= 1'b0;
        end else begin
            level            <= levelNext;
            wrPtr            <= push ? wrPtr + 1'b1 : wrPtr;
            rdPtr            <= bus.flush ? wrPtr : pop ? rdPtr + 1'b1 : rdPtr;
            bus.overflow     <= drop || (bus.overflow && !bus.ovfClear);
            bus.lowWaterIrq  <= bus.irqEn && (levelNext <= bus.lowWater);
            bus.txDataOut    <= pop ? mem[rdPtr] : bus.txDataOut;
            bus.txDataLoadEn <= pop;
            case (state)
                IDLE:    state <= pop ? LOAD : IDLE;
                LOAD:    state <= SETTLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenario tests for uart_tx_fifo with a small txReady core model
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();
    uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
    int total = 0;
    int bad = 0;
    logic coreAuto = 1'b0;
    logic manualReady = 1'b0;
    logic modelReady = 1'b1;
    int busy = 0;
    logic [7:0] captured[$];
    assign bus.txReady = coreAuto ? modelReady : manualReady;
    // core model: latches each load, drops txReady next cycle, recovers after a few cycles
    always @(posedge clk) begin
        if (bus.txDataLoadEn) begin
            captured.push_back(bus.txDataOut);
            modelReady <= 1'b0;
            busy <= 3;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) modelReady <= 1'b1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d);
        bus.wrData = d;
        bus.wrEn = 1'b1;
        tick();
        bus.wrEn = 1'b0;
    endtask
    task automatic waitCap(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (captured.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask
    task automatic test_reset();
        #2 reset = 1'b1;
        #2;
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.lowWaterIrq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", bus.lowWaterIrq); end
        total++; if (bus.txDataOut !== 8'h00) begin bad++; $display("FAIL rst_txData got=%h exp=00", bus.txDataOut); end
        total++; if (bus.txDataLoadEn !== 1'b0) begin bad++; $display("FAIL rst_loadEn got=%b exp=0", bus.txDataLoadEn); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask
    task automatic test_latency();
        manualReady = 1'b1;
        bus.wrData = 8'hA5;
        bus.wrEn = 1'b1;
        tick();
        bus.wrEn = 1'b0;
        total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL lat_level1 got=%0d exp=1", bus.level); end
        total++; if (bus.txDataLoadEn !== 1'b0) begin bad++; $display("FAIL lat_loadEn_c1 got=%b exp=0", bus.txDataLoadEn); end
        tick();
        total++; if (bus.txDataLoadEn !== 1'b1) begin bad++; $display("FAIL lat_loadEn_c2 got=%b exp=1", bus.txDataLoadEn); end
        total++; if (bus.txDataOut !== 8'hA5) begin bad++; $display("FAIL lat_txData got=%h exp=a5", bus.txDataOut); end
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL lat_level0 got=%0d exp=0", bus.level); end
        tick();
        total++; if (bus.txDataLoadEn !== 1'b0) begin bad++; $display("FAIL lat_loadEn_c3 got=%b exp=0", bus.txDataLoadEn); end
        manualReady = 1'b0;
        tick();
    endtask
    task automatic test_full_overflow();
        int base;
        bit ok;
        base = captured.size();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", bus.full); end
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", bus.level); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_noovf got=%b exp=0", bus.overflow); end
        push(8'hEE);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
        coreAuto = 1'b1;
        waitCap(base + DEPTH, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain_timeout got=%0d exp=%0d", captured.size() - base, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (captured[base+i] !== 8'(i)) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, captured[base+i], 8'(i)); end
        end
        repeat (4) tick();
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
        bus.ovfClear = 1'b1;
        tick();
        bus.ovfClear = 1'b0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_drained_empty got=%b exp=1", bus.empty); end
        coreAuto = 1'b0;
    endtask
    task automatic test_back_to_back();
        int base;
        bit ok;
        base = captured.size();
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        total++; if (bus.level !== 5'd5) begin bad++; $display("FAIL b2b_level_pre got=%0d exp=5", bus.level); end
        bus.wrData = 8'h35;
        bus.wrEn = 1'b1;
        manualReady = 1'b1;
        tick();
        bus.wrEn = 1'b0;
        manualReady = 1'b0;
        total++; if (bus.level !== 5'd5) begin bad++; $display("FAIL b2b_level_same got=%0d exp=5", bus.level); end
        total++; if (bus.txDataLoadEn !== 1'b1) begin bad++; $display("FAIL b2b_loadEn got=%b exp=1", bus.txDataLoadEn); end
        total++; if (bus.txDataOut !== 8'h30) begin bad++; $display("FAIL b2b_txData got=%h exp=30", bus.txDataOut); end
        coreAuto = 1'b1;
        for (int i = 0; i < 14; i++) begin
            push(8'(8'h36 + i));
            tick();
        end
        waitCap(base + 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d exp=20", captured.size() - base); end
        for (int i = 0; i < 20; i++) begin
            total++; if (captured[base+i] !== 8'(8'h30 + i)) begin bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, captured[base+i], 8'(8'h30 + i)); end
        end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_noovf got=%b exp=0", bus.overflow); end
        repeat (4) tick();
        coreAuto = 1'b0;
    endtask
    task automatic test_irq();
        int base;
        bit ok;
        base = captured.size();
        bus.lowWater = 5'd2;
        bus.irqEn = 1'b1;
        tick();
        total++; if (bus.lowWaterIrq !== 1'b1) begin bad++; $display("FAIL irq_empty got=%b exp=1", bus.lowWaterIrq); end
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        total++; if (bus.lowWaterIrq !== 1'b0) begin bad++; $display("FAIL irq_level4 got=%b exp=0", bus.lowWaterIrq); end
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        total++; if (bus.level !== 5'd3) begin bad++; $display("FAIL irq_lvl3 got=%0d exp=3", bus.level); end
        total++; if (bus.lowWaterIrq !== 1'b0) begin bad++; $display("FAIL irq_level3 got=%b exp=0", bus.lowWaterIrq); end
        tick();
        tick();
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        total++; if (bus.level !== 5'd2) begin bad++; $display("FAIL irq_lvl2 got=%0d exp=2", bus.level); end
        total++; if (bus.lowWaterIrq !== 1'b1) begin bad++; $display("FAIL irq_level2 got=%b exp=1", bus.lowWaterIrq); end
        bus.irqEn = 1'b0;
        tick();
        total++; if (bus.lowWaterIrq !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b exp=0", bus.lowWaterIrq); end
        coreAuto = 1'b1;
        waitCap(base + 4, ok);
        total++; if (!ok) begin bad++; $display("FAIL irq_drain_timeout got=%0d exp=4", captured.size() - base); end
        repeat (4) tick();
        coreAuto = 1'b0;
    endtask
    task automatic test_flush();
        int base;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        base = captured.size();
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        total++; if (bus.txDataLoadEn !== 1'b1) begin bad++; $display("FAIL flush_inload got=%b exp=1", bus.txDataLoadEn); end
        total++; if (bus.txDataOut !== 8'h60) begin bad++; $display("FAIL flush_txData got=%h exp=60", bus.txDataOut); end
        bus.flush = 1'b1;
        bus.wrData = 8'h99;
        bus.wrEn = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.wrEn = 1'b0;
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", bus.level); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL flush_noovf got=%b exp=0", bus.overflow); end
        manualReady = 1'b1;
        repeat (10) tick();
        manualReady = 1'b0;
        total++; if (captured.size() !== base + 1) begin bad++; $display("FAIL flush_loads got=%0d exp=1", captured.size() - base); end
        total++; if (captured[base] !== 8'h60) begin bad++; $display("FAIL flush_byte got=%h exp=60", captured[base]); end
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL flush_level_after got=%0d exp=0", bus.level); end
    endtask
    task automatic test_reset_async();
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        push(8'hEE);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL arst_pre_ovf got=%b exp=1", bus.overflow); end
        manualReady = 1'b1;
        tick();
        manualReady = 1'b0;
        total++; if (bus.txDataLoadEn !== 1'b1) begin bad++; $display("FAIL arst_pre_loadEn got=%b exp=1", bus.txDataLoadEn); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.txDataLoadEn !== 1'b0) begin bad++; $display("FAIL arst_loadEn got=%b exp=0", bus.txDataLoadEn); end
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", bus.level); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL arst_ovf got=%b exp=0", bus.overflow); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b exp=1", bus.empty); end
        tick();
        reset = 1'b0;
        tick();
    endtask
    initial begin
        bus.wrData = 8'h00;
        bus.wrEn = 1'b0;
        bus.flush = 1'b0;
        bus.ovfClear = 1'b0;
        bus.lowWater = 5'd0;
        bus.irqEn = 1'b0;
        test_reset();
        test_latency();
        test_full_overflow();
        test_back_to_back();
        test_irq();
        test_flush();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
